// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage (IF FSM states, bubble word, PC step).
package instruction_fetch_stage_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: holds on stall, otherwise loads a delivered instruction or a bubble.
module if_id_register
  import instruction_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;

  // An unstalled cycle without a delivery must bubble so decode never sees a repeat.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    if (!stall) begin
      instr_d = load ? instr_in : NOP_INSTR;
      pc_d    = load ? pc_in : 32'h0;
      vld_d   = load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
      vld_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = vld_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, request FSM (REQ/HOLD/DRAIN) and 1-entry stall hold buffer.
// Optional perf counters FetchCount/FlushCount are built when IF_PERF_CNT_EN is defined.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] JumpAddress,
  input  logic        BranchOut,
  input  logic [31:0] BranchAddress,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] Instruction,
  output logic [31:0] PCResult,
  output logic        InstrValid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;

  logic         redirect;
  logic [31:0]  target, pc_inc;
  logic         deliver;
  logic [31:0]  deliver_instr, deliver_pc;

  // Only a valid instruction in decode can redirect, and only when not frozen.
  assign redirect = !Stall && InstrValid && (Jump || BranchOut);
  assign target   = align_word(Jump ? JumpAddress : BranchAddress);
  assign pc_inc   = pc_q + PC_INC;

  assign ImemReq  = Rst_n && (state_q != HOLD);
  assign ImemAddr = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    deliver       = 1'b0;
    deliver_instr = NOP_INSTR;
    deliver_pc    = 32'h0;
    unique case (state_q)
      REQ: begin
        if (Stall) begin
          if (ImemAck) begin
            hold_instr_d = ImemData;
            hold_pc_d    = pc_inc;
            pc_d         = pc_inc;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          if (ImemAck) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = DRAIN;
          end
        end else if (ImemAck) begin
          deliver       = 1'b1;
          deliver_instr = ImemData;
          deliver_pc    = pc_inc;
          pc_d          = pc_inc;
        end
      end
      HOLD: begin
        if (!Stall) begin
          state_d = REQ;
          if (redirect) begin
            pc_d = target;
          end else begin
            deliver       = 1'b1;
            deliver_instr = hold_instr_q;
            deliver_pc    = hold_pc_q;
          end
        end
      end
      DRAIN: begin
        // The redirect is already committed, so the stale response retires even under stall.
        if (ImemAck) begin
          pc_d    = tgt_q;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_VECTOR;
      tgt_q        <= 32'h0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  if_id_register u_if_id (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .stall    (Stall),
    .load     (deliver),
    .instr_in (deliver_instr),
    .pc_in    (deliver_pc),
    .instr_o  (Instruction),
    .pc_o     (PCResult),
    .valid_o  (InstrValid)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        flush_evt;

  assign flush_evt = ((state_q == REQ) && redirect && ImemAck) ||
                     ((state_q == HOLD) && redirect) ||
                     ((state_q == DRAIN) && ImemAck);

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (deliver ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (flush_evt ? 32'd1 : 32'd0);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule
